axi_slave_mem_bank: RTL and testbench
=====================================

Name: axi_slave_mem_bank

Overview:
- Single-port word-addressed SRAM bank model with a fixed-latency read pipeline. It sits directly downstream of the AXI slave memory wrapper and consumes its data_req/data_add/data_wen/data_wdata/data_be request stream.
- Returns data_gnt, data_r_valid and data_r_rdata back to the wrapper.
- Programmable grant stalls exercise the wrapper's read-ahead FIFO and its backpressure paths.

Parameters:
- AXI_DATA_WIDTH, 32, word width in bits.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, byte-enable width.
- AXI_ADDR_WIDTH, 32, byte address width.
- DATA_MEM_LENGTH, 256, number of words in the bank.
- ADDR_LSB, $clog2(AXI_DATA_WIDTH/8), byte-to-word shift.
- ADDR_BASE_OFFSET, 0, byte address of word 0.
- READ_LATENCY, 2, cycles from read grant to data_r_valid_o; legal range 1..4.
- STALL_EVERY, 0, grant-stall period in granted requests; 0 disables stalls.
- STALL_CYCLES, 1, number of cycles data_gnt_o is held low per stall; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_req_i  in  1  request valid; held with stable payload until granted.
- data_add_i  in  AXI_ADDR_WIDTH  byte address.
- data_wen_i  in  1  1 = write, 0 = read.
- data_wdata_i  in  AXI_DATA_WIDTH  write data.
- data_be_i  in  AXI_STRB_WIDTH  byte enables for writes.
- data_gnt_o  out  1  request accepted this cycle (combinational from data_req_i and stall state).
- data_r_valid_o  out  1  read data valid; asserted for reads only.
- data_r_rdata_o  out  AXI_DATA_WIDTH  read data.
- addr_err_o  out  1  one-cycle pulse marking an out-of-range access.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high; port name reset.
- Reset values:
  - data_r_valid_o = 0, data_r_rdata_o = 0, addr_err_o = 0.
  - Read pipeline valid bits = 0; stall counters = 0.
  - data_gnt_o = 0 while reset is high.
  - Memory array contents are not reset.
- Accept:
  - A request is accepted on a cycle with data_req_i & data_gnt_o.
  - data_gnt_o = data_req_i & ~stalling.
  - Throughput is one accepted request per cycle; there is no bubble between back-to-back accepts.
- Address decode:
  - idx = (data_add_i - ADDR_BASE_OFFSET) >> ADDR_LSB.
  - In range iff data_add_i >= ADDR_BASE_OFFSET and idx < DATA_MEM_LENGTH.
  - Low ADDR_LSB address bits are ignored.
- Write:
  - Accepted at cycle T: byte lane i of word idx updated at the end of T iff data_be_i[i]=1.
  - be = 0 is accepted with no change to memory.
  - No data_r_valid_o is produced for a write.
- Read:
  - Accepted at cycle T: data_r_valid_o = 1 at cycle T+READ_LATENCY.
  - data_r_rdata_o = mem[idx] as it stands after all writes accepted at or before T-1.
  - A write accepted at T and a read of the same word at T+1 returns the new data.
  - data_r_rdata_o holds its last value when data_r_valid_o = 0.
- Pipeline:
  - READ_LATENCY-deep shift of {valid, data, err}.
  - The pipeline never stalls; there is no r_ready. The consumer must absorb every response.
- Out-of-range access:
  - Request is still granted; a write is dropped.
  - A read returns data 0 with data_r_valid_o = 1 at T+READ_LATENCY.
  - addr_err_o pulses in that same cycle for a read, and at T+1 for a write.
- Stall FSM (active only when STALL_EVERY > 0):
  - States IDLE_CNT and STALL.
  - In IDLE_CNT, grant_cnt increments on each accept. When an accept makes grant_cnt == STALL_EVERY, go to STALL next cycle and clear grant_cnt.
  - In STALL, stalling = 1 for exactly STALL_CYCLES cycles, counted by stall_cnt, regardless of data_req_i; then return to IDLE_CNT.
  - In-flight reads continue to drain during STALL.
- Simultaneous events:
  - A stall entry does not revoke the grant already given in the cycle that hit the count.
- Reset mid-operation:
  - In-flight reads are discarded; no data_r_valid_o appears after reset.
  - The FSM returns to IDLE_CNT.
  - A write accepted in the same cycle as reset is not performed.
- Latency of data_gnt_o from data_req_i is 0 cycles (combinational). There is no combinational path from data_add_i to data_r_rdata_o.

Test Plan:
- Single read, READ_LATENCY=2: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 accepted at cycle 10 -> data_r_valid_o=1 only at cycle 12, data_r_rdata_o=0xDEADBEEF.
- Byte enables: preload 0x11223344 at 0x20, write 0xAABBCCDD with be=0b0101 -> a subsequent read returns 0x11BB33DD.
- Streaming: 8 back-to-back reads of 0x0..0x1C, req held high -> 8 grants in 8 cycles; r_valid high for 8 consecutive cycles starting 2 cycles later; data in address order.
- Write-then-read hazard: write 0x5A5A5A5A to 0x40 at T, read 0x40 at T+1 -> returns 0x5A5A5A5A.
- Stall, STALL_EVERY=3, STALL_CYCLES=2, req held high -> gnt pattern 1,1,1,0,0,1,1,1,0,0; no lost or duplicated responses.
- Range and reset:
  - Read at ADDR_BASE_OFFSET+DATA_MEM_LENGTH*4 -> rdata=0 with addr_err_o pulse aligned to r_valid.
  - Assert reset with 2 reads in flight -> no r_valid afterwards; outputs 0.

Source files
------------

// File: rtl/axi_slave_mem_bank.sv
// Word-addressed single-port SRAM bank behind the AXI slave memory wrapper.
// Fixed-latency read pipeline, byte-enabled writes and optional periodic grant stalls.
module axi_slave_mem_bank #(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_STRB_WIDTH   = AXI_DATA_WIDTH / 8,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int DATA_MEM_LENGTH  = 256,
  parameter int ADDR_LSB         = $clog2(AXI_DATA_WIDTH / 8),
  parameter int ADDR_BASE_OFFSET = 0,
  parameter int READ_LATENCY     = 2,
  parameter int STALL_EVERY      = 0,
  parameter int STALL_CYCLES     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      data_req_i,
  input  logic [AXI_ADDR_WIDTH-1:0] data_add_i,
  input  logic                      data_wen_i,
  input  logic [AXI_DATA_WIDTH-1:0] data_wdata_i,
  input  logic [AXI_STRB_WIDTH-1:0] data_be_i,
  output logic                      data_gnt_o,
  output logic                      data_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                      addr_err_o
);

  localparam int IDX_W = (DATA_MEM_LENGTH > 1) ? $clog2(DATA_MEM_LENGTH) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(ADDR_BASE_OFFSET);
  localparam logic [AXI_ADDR_WIDTH-1:0] LEN  = AXI_ADDR_WIDTH'(DATA_MEM_LENGTH);
  localparam bit          STALL_EN   = (STALL_EVERY > 0);
  localparam logic [15:0] GCNT_LAST  = 16'(STALL_EVERY - 1);
  localparam logic [3:0]  SCNT_LAST  = 4'(STALL_CYCLES - 1);

  typedef enum logic {IDLE_CNT, STALL} stall_state_e;

  function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [AXI_DATA_WIDTH-1:0] old_w,
    input logic [AXI_DATA_WIDTH-1:0] new_w,
    input logic [AXI_STRB_WIDTH-1:0] be
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

  stall_state_e              state_q;
  logic [15:0]               grant_cnt_q;
  logic [3:0]                stall_cnt_q;
  logic                      stalling;
  logic                      accept;

  logic [AXI_ADDR_WIDTH-1:0] off;
  logic [AXI_ADDR_WIDTH-1:0] widx;
  logic [IDX_W-1:0]          idx;
  logic                      in_range;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DATA_MEM_LENGTH];
  logic                      mem_we;
  logic                      rd_acc;
  logic [AXI_DATA_WIDTH-1:0] rd_word;

  logic [READ_LATENCY-1:0]   vld_q, vld_d;
  logic [READ_LATENCY-1:0]   err_q, err_d;
  logic [AXI_DATA_WIDTH-1:0] dat_q [READ_LATENCY];
  logic [AXI_DATA_WIDTH-1:0] dat_d [READ_LATENCY];
  logic                      wr_err_q, wr_err_d;

  // Request decode and grant
  always_comb begin
    off      = data_add_i - BASE;
    widx     = off >> ADDR_LSB;
    in_range = (data_add_i >= BASE) && (widx < LEN);
    idx      = widx[IDX_W-1:0];
  end

  assign stalling   = (state_q == STALL);
  assign data_gnt_o = data_req_i & ~stalling & ~reset;
  assign accept     = data_gnt_o;
  assign mem_we     = accept & data_wen_i & in_range;
  assign rd_acc     = accept & ~data_wen_i;
  assign rd_word    = in_range ? mem_q[idx] : '0;
  assign wr_err_d   = accept & data_wen_i & ~in_range;

  // Array is not reset; grant is already blocked while reset is high
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= merge_bytes(mem_q[idx], data_wdata_i, data_be_i);
  end

  // Read pipeline: stage 0 captures the array, later stages only advance on valid
  // so the final stage holds the last returned word.
  always_comb begin
    vld_d    = '0;
    err_d    = err_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    if (rd_acc) begin
      dat_d[0] = rd_word;
      err_d[0] = ~in_range;
    end
    for (int k = 1; k < READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        dat_d[k] = dat_q[k-1];
        err_d[k] = err_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wr_err_q <= wr_err_d;
    end
    err_q <= err_d;
    for (int k = 0; k < READ_LATENCY; k++) begin
      dat_q[k] <= (reset && (k == READ_LATENCY - 1)) ? '0 : dat_d[k];
    end
  end

  // Output stage
  assign data_r_valid_o = vld_q[READ_LATENCY-1];
  assign data_r_rdata_o = dat_q[READ_LATENCY-1];
  assign addr_err_o     = wr_err_q | (vld_q[READ_LATENCY-1] & err_q[READ_LATENCY-1]);

  // Stall FSM: the accept that reaches the count keeps its grant, stalling starts next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE_CNT;
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE_CNT: begin
          if (STALL_EN && accept) begin
            if (grant_cnt_q == GCNT_LAST) begin
              state_q     <= STALL;
              grant_cnt_q <= '0;
              stall_cnt_q <= '0;
            end else begin
              grant_cnt_q <= grant_cnt_q + 16'd1;
            end
          end
        end
        STALL: begin
          if (stall_cnt_q == SCNT_LAST) begin
            state_q     <= IDLE_CNT;
            stall_cnt_q <= '0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE_CNT;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_bank.sv
// Directed bench for axi_slave_mem_bank: one plain instance and one with grant stalls.
module tb_axi_slave_mem_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req, wen;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, aerr;
  logic [31:0] rdata;

  logic        s_req, s_wen;
  logic [31:0] s_add, s_wdata;
  logic [3:0]  s_be;
  logic        s_gnt, s_rvalid, s_aerr;
  logic [31:0] s_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_slave_mem_bank u_dut (
    .clk(clk), .reset(reset),
    .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
    .data_wdata_i(wdata), .data_be_i(be),
    .data_gnt_o(gnt), .data_r_valid_o(rvalid),
    .data_r_rdata_o(rdata), .addr_err_o(aerr)
  );

  axi_slave_mem_bank #(.STALL_EVERY(3), .STALL_CYCLES(2)) u_stl (
    .clk(clk), .reset(reset),
    .data_req_i(s_req), .data_add_i(s_add), .data_wen_i(s_wen),
    .data_wdata_i(s_wdata), .data_be_i(s_be),
    .data_gnt_o(s_gnt), .data_r_valid_o(s_rvalid),
    .data_r_rdata_o(s_rdata), .addr_err_o(s_aerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    req = 1'b0; wen = 1'b0; add = '0; wdata = '0; be = '0;
  endtask

  task automatic drv_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; wen = 1'b1; add = a; wdata = d; be = b;
  endtask

  task automatic drv_r(input logic [31:0] a);
    req = 1'b1; wen = 1'b0; add = a; wdata = '0; be = '0;
  endtask

  // Read issued at T, checked in cycle T+2; returns in cycle T+2 with req low
  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drv_r(a);
    #1 chkb({tag, "_gnt"}, gnt, 1'b1);
    tick();
    idle();
    #1 chkb({tag, "_vld_early"}, rvalid, 1'b0);
    tick();
    #1 chkb({tag, "_vld"}, rvalid, 1'b1);
    chk({tag, "_data"}, rdata, exp);
  endtask

  function automatic logic [31:0] sval(input int i);
    return 32'hA000_0000 | (32'(i) * 32'h11);
  endfunction

  initial begin
    int k;
    int j;
    int resp;
    idle();
    s_req = 1'b0; s_wen = 1'b0; s_add = '0; s_wdata = '0; s_be = '0;
    repeat (3) tick();

    // Reset state, grant suppressed while reset is high
    req = 1'b1;
    s_req = 1'b1;
    #1 chkb("rst_gnt", gnt, 1'b0);
    chkb("rst_s_gnt", s_gnt, 1'b0);
    chkb("rst_vld", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chkb("rst_aerr", aerr, 1'b0);
    tick();
    idle();
    s_req = 1'b0;
    reset = 1'b0;
    tick();

    // Stall pattern with writes: 1,1,1,0,0 repeating
    k = 0;
    for (int c = 0; c < 10; c++) begin
      s_req = 1'b1; s_wen = 1'b1; s_add = 32'(k * 4);
      s_wdata = 32'hC0DE_0000 + 32'(k); s_be = 4'hF;
      #1 chkb("stall_gnt_w", s_gnt, (c % 5) < 3);
      chkb("stall_no_rvalid_w", s_rvalid, 1'b0);
      if (s_gnt) k++;
      tick();
    end
    chk("stall_wr_count", 32'(k), 32'd6);

    // Stall pattern with reads: every response present, once, in order
    j = 0;
    resp = 0;
    for (int c = 0; c < 12; c++) begin
      if (j < 6) begin
        s_req = 1'b1; s_wen = 1'b0; s_add = 32'(j * 4); s_be = '0;
      end else begin
        s_req = 1'b0;
      end
      #1;
      if (j < 6) chkb("stall_gnt_r", s_gnt, (c % 5) < 3);
      if (s_rvalid) begin
        chk("stall_rdata", s_rdata, 32'hC0DE_0000 + 32'(resp));
        resp++;
      end
      if (s_req && s_gnt) j++;
      tick();
    end
    chk("stall_resp_count", 32'(resp), 32'd6);
    s_req = 1'b0;

    // Single write then read, latency and hold
    drv_w(32'h10, 32'hDEAD_BEEF, 4'hF);
    #1 chkb("w10_gnt", gnt, 1'b1);
    tick();
    read_check("rd10", 32'h10, 32'hDEAD_BEEF);
    chkb("rd10_aerr", aerr, 1'b0);
    tick();
    #1 chkb("rd10_vld_drop", rvalid, 1'b0);
    chk("rd10_hold", rdata, 32'hDEAD_BEEF);

    // Byte enables, be=0 write, low address bits ignored
    drv_w(32'h20, 32'h1122_3344, 4'hF); tick();
    drv_w(32'h20, 32'hAABB_CCDD, 4'b0101); tick();
    drv_w(32'h20, 32'hFFFF_FFFF, 4'b0000); tick();
    read_check("be", 32'h23, 32'h11BB_33DD);
    tick();

    // Write then read of the same word on the next cycle
    drv_w(32'h40, 32'h5A5A_5A5A, 4'hF);
    #1 chkb("haz_w_gnt", gnt, 1'b1);
    tick();
    read_check("haz", 32'h40, 32'h5A5A_5A5A);
    tick();

    // Streaming reads
    for (int i = 0; i < 8; i++) begin
      drv_w(32'(i * 4), sval(i), 4'hF);
      tick();
    end
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drv_r(32'(c * 4));
      else idle();
      #1;
      if (c < 8) chkb("strm_gnt", gnt, 1'b1);
      chkb("strm_vld", rvalid, (c >= 2) && (c < 10));
      if ((c >= 2) && (c < 10)) chk("strm_data", rdata, sval(c - 2));
      tick();
    end

    // Out-of-range read: zero data, error aligned with valid
    drv_r(32'h400);
    #1 chkb("oor_r_gnt", gnt, 1'b1);
    tick();
    idle();
    #1 chkb("oor_r_aerr_early", aerr, 1'b0);
    tick();
    #1 chkb("oor_r_vld", rvalid, 1'b1);
    chk("oor_r_data", rdata, 32'h0);
    chkb("oor_r_aerr", aerr, 1'b1);
    tick();
    #1 chkb("oor_r_aerr_end", aerr, 1'b0);

    // Out-of-range write: dropped, error one cycle later, no valid
    drv_w(32'h400, 32'hFFFF_FFFF, 4'hF);
    #1 chkb("oor_w_gnt", gnt, 1'b1);
    tick();
    idle();
    #1 chkb("oor_w_aerr", aerr, 1'b1);
    chkb("oor_w_vld", rvalid, 1'b0);
    tick();
    #1 chkb("oor_w_aerr_end", aerr, 1'b0);
    read_check("oor_w_drop", 32'h0, sval(0));
    tick();

    // Reset with reads in flight and a write presented during reset
    drv_r(32'h10); tick();
    drv_r(32'h400); tick();
    drv_w(32'h10, 32'h0, 4'hF);
    reset = 1'b1;
    #1 chkb("mid_rst_gnt", gnt, 1'b0);
    tick();
    reset = 1'b0;
    idle();
    for (int c = 0; c < 4; c++) begin
      #1 chkb("mid_rst_vld", rvalid, 1'b0);
      chk("mid_rst_rdata", rdata, 32'h0);
      chkb("mid_rst_aerr", aerr, 1'b0);
      tick();
    end
    read_check("mid_rst_wdrop", 32'h10, sval(4));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
